float_to_int: RTL
=================

Name: float_to_int

Overview:
- Downstream neighbour of the single-precision divider.
- Consumes an IEEE-754 single-precision result over the standard stb/ack handshake.
- Produces a signed 32-bit two's-complement integer, rounded toward zero.
- Out-of-range values and NaN saturate to a fixed value.
- Multi-cycle; the magnitude shift is iterative, one bit per cycle, to keep area small.

Parameters:
- SAT_VALUE, 32'h80000000, result for NaN, ±inf and any |value| >= 2^31 (except exactly -2^31).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- input_a  input  32  IEEE-754 single operand
- input_a_stb  input  1  operand valid
- input_a_ack  output  1  operand accepted (registered)
- output_z  output  32  signed integer result (registered)
- output_z_stb  output  1  result valid (registered)
- output_z_ack  input  1  consumer accepted result

Behaviour:
- Reset (rst low, asynchronous, any state):
  - state=get_a; input_a_ack=0, output_z_stb=0, output_z=0.
  - An in-flight operand is discarded.
  - First ack rises on the first clock edge after release.
- States: get_a -> unpack -> special_cases -> convert -> pack -> put_z -> get_a.
- get_a:
  - Drive input_a_ack=1.
  - Transfer occurs on the edge where input_a_ack && input_a_stb.
  - On transfer: latch operand, ack<=0, go to unpack.
  - stb without ack high is ignored.
- unpack:
  - m (32b) <= {1'b1, input[22:0], 8'b0}.
  - e (10b signed) <= input[30:23]-127.
  - s <= input[31].
  - 1 cycle.
- special_cases, priority order:
  - e==128 (inf or NaN): z<=SAT_VALUE -> put_z.
  - e < 0 (includes zero, denormals, |x|<1): z<=0 -> put_z. Sign is ignored, so -0.7 -> 0.
  - e >= 31: z<=SAT_VALUE -> put_z. Covers +2^31 and -2^31; -2^31 yields 0x80000000, which equals SAT_VALUE and is correct.
  - Otherwise go to convert.
- convert:
  - Each cycle while e<31: m<=m>>1, e<=e+1.
  - When e==31, go to pack.
  - Occupancy is (31-e_initial) cycles; e.g. 1.0 takes 31 cycles.
  - Fraction bits are shifted out and discarded (truncation toward zero); no guard/round/sticky.
- pack: z <= s ? -m : m (32-bit two's complement). 1 cycle.
- put_z:
  - output_z_stb<=1, output_z<=z.
  - Completes on the edge where output_z_stb && output_z_ack: stb<=0, go to get_a.
  - output_z holds its value after completion until the next put_z.
- Handshake rules:
  - input_a_ack and output_z_stb are never high in the same cycle.
  - At most one operand is in flight (no pipelining).
  - An ack held high before stb rises is legal.
  - A consumer holding output_z_ack permanently high yields one-cycle stb pulses.
- Latency, accepting edge to stb high:
  - Normal value: 3 + (31-e) + 1 cycles.
  - Special case: 3 cycles.
- Width rules:
  - e is held in 10 bits signed, so exp 0..255 maps to -127..128 without wrap.
  - Negation is 32-bit modulo.

Decomposition:
- Shared fpu package holds:
  - state encoding (4-bit, same ordinal style as the other fpu blocks)
  - EXP_BIAS=127, EXP_SPECIAL=128
  - canonical constants, shared with the divider and the future int_to_float: SAT_VALUE, QNAN=32'hffc00000
- No sub-module is warranted. The shift loop and negate are inline in the single FSM.

Test Plan:
- 32'h3f800000 (1.0) -> output_z=32'h00000001, stb exactly 35 cycles after the accepting edge.
- 32'hc2f6e979 (-123.456) -> 32'hffffff85 (-123), truncation toward zero.
- 32'h4f000000 (+2^31) -> 32'h80000000; 32'hcf000000 (-2^31) -> 32'h80000000; 32'h4effffff -> 32'h7fffff80.
- 32'h7fc00000 (NaN) and 32'hff800000 (-inf) -> 32'h80000000. 32'h80000000 (-0), 32'h00000001 (denormal) and 32'hbf333333 (-0.7) -> 32'h00000000, each 3-cycle latency.
- Back-to-back operands with output_z_ack held low 10 cycles:
  - stb stays high and output_z stable.
  - input_a_ack stays 0 until one cycle after the result handshake.
  - Results return in order.
- Assert rst low mid-convert (operand 1.0, 10 cycles in), release:
  - All outputs 0 immediately (asynchronous).
  - Next operand 32'h41200000 -> 32'h0000000a with no residue from the aborted operation.

Source files
------------

// File: rtl/float_to_int_pkg.sv
// rtl/float_to_int_pkg.sv - shared fpu state encoding and canonical constants
package float_to_int_pkg;

  typedef enum logic [3:0] {
    GET_A         = 4'd0,
    UNPACK        = 4'd1,
    SPECIAL_CASES = 4'd2,
    CONVERT       = 4'd3,
    PACK          = 4'd4,
    PUT_Z         = 4'd5
  } fpu_state_e;

  localparam int          EXP_BIAS    = 127;
  localparam int          EXP_SPECIAL = 128;

  // Shared with the divider and int_to_float.
  localparam logic [31:0] FPU_SAT_VALUE = 32'h80000000;
  localparam logic [31:0] QNAN          = 32'hffc00000;

endpackage

// File: rtl/float_to_int.sv
// rtl/float_to_int.sv - IEEE-754 single to signed 32-bit integer, round toward zero
module float_to_int
  import float_to_int_pkg::*;
#(
  parameter logic [31:0] SAT_VALUE = FPU_SAT_VALUE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  fpu_state_e         state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        m_q, m_d;
  logic signed [9:0]  e_q, e_d;
  logic               s_q, s_d;
  logic [31:0]        z_q, z_d;
  logic               ack_q, ack_d;
  logic               stb_q, stb_d;
  logic [31:0]        out_q, out_d;

  localparam logic signed [9:0] BIAS    = 10'(EXP_BIAS);
  localparam logic signed [9:0] SPECIAL = 10'(EXP_SPECIAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      m_q     <= '0;
      e_q     <= '0;
      s_q     <= 1'b0;
      z_q     <= '0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      e_q     <= e_d;
      s_q     <= s_d;
      z_q     <= z_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    e_d     = e_q;
    s_d     = s_q;
    z_d     = z_q;
    ack_d   = ack_q;
    stb_d   = stb_q;
    out_d   = out_q;
    case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (ack_q && input_a_stb) begin
          a_d     = input_a;
          ack_d   = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        m_d     = {1'b1, a_q[22:0], 8'b0};
        e_d     = $signed({2'b00, a_q[30:23]}) - BIAS;
        s_d     = a_q[31];
        state_d = SPECIAL_CASES;
      end
      SPECIAL_CASES: begin
        if (e_q == SPECIAL) begin
          z_d     = SAT_VALUE;
          state_d = PUT_Z;
        end else if (e_q < 10'sd0) begin
          z_d     = '0;
          state_d = PUT_Z;
        end else if (e_q >= 10'sd31) begin
          z_d     = SAT_VALUE;
          state_d = PUT_Z;
        end else begin
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        // Exits on the shift that brings e to 31, so no idle cycle is spent at e==31.
        m_d = m_q >> 1;
        e_d = e_q + 10'sd1;
        if (e_q == 10'sd30) state_d = PACK;
      end
      PACK: begin
        z_d     = s_q ? (~m_q + 32'd1) : m_q;
        state_d = PUT_Z;
      end
      PUT_Z: begin
        stb_d = 1'b1;
        out_d = z_q;
        if (stb_q && output_z_ack) begin
          stb_d   = 1'b0;
          state_d = GET_A;
        end
      end
      default: begin
        ack_d   = 1'b0;
        stb_d   = 1'b0;
        state_d = GET_A;
      end
    endcase
  end

  assign input_a_ack  = ack_q;
  assign output_z_stb = stb_q;
  assign output_z     = out_q;

endmodule
